// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller.
package int_ctrl_pkg;

  // Number of interrupt sources; the controller is built for exactly 8.
  localparam int unsigned N_SRC = 8;

  // Width of a source index (0..N_SRC-1).
  localparam int unsigned ID_W = 3;

  // Word register indices (bus byte address bits 4:2).
  typedef enum logic [2:0] {
    REG_PEND     = 3'd0,
    REG_ENABLE   = 3'd1,
    REG_MODE     = 3'd2,
    REG_CLAIM    = 3'd3,
    REG_COMPLETE = 3'd4,
    REG_INSERV   = 3'd5
  } reg_idx_e;

  // CLAIM read value when no source is eligible.
  localparam logic [31:0] CLAIM_NONE = 32'd0;

  // Map a 1-based interrupt id (1..N_SRC) to a one-hot source mask;
  // any other id maps to an empty mask.
  function automatic logic [N_SRC-1:0] id_to_mask(input logic [3:0] id);
    logic [3:0] idx;
    id_to_mask = '0;
    idx        = id - 4'd1;
    if ((id >= 4'd1) && (id <= 4'd8)) begin
      id_to_mask[idx[ID_W-1:0]] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  // Scan from the top down so the lowest set bit is the last one assigned.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (vec[i-1]) begin
        valid = 1'b1;
        idx   = ID_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: 8 sources, per-source edge/level mode, enable,
// claim/complete handshake with in-service tracking and strict-priority
// preemption. irq is a registered request for one CPU interrupt line.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = int_ctrl_pkg::N_SRC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             sel,
  input  logic             we,
  input  logic [2:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  // Synchronizer stages (1,2) and edge-detect history (3).
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;
  logic [N_SRC-1:0] sync3_q, sync3_d;

  // Architectural registers.
  logic [N_SRC-1:0] pend_q,   pend_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] mode_q,   mode_d;
  logic [N_SRC-1:0] inserv_q, inserv_d;
  logic             irq_q,    irq_d;

  // Decoded bus strobes.
  logic wr_pend;
  logic wr_enable;
  logic wr_mode;
  logic wr_complete;
  logic rd_claim;

  // Priority information.
  logic [N_SRC-1:0] eligible;
  logic             elig_valid;
  logic [ID_W-1:0]  best_idx;
  logic             inserv_valid;
  logic [ID_W-1:0]  inserv_idx;

  // Per-source update masks.
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] claim_mask;
  logic [N_SRC-1:0] complete_mask;
  logic [N_SRC-1:0] pend_clr;

  // Bus access decode.
  always_comb begin
    wr_pend     = sel & we  & (addr == REG_PEND);
    wr_enable   = sel & we  & (addr == REG_ENABLE);
    wr_mode     = sel & we  & (addr == REG_MODE);
    wr_complete = sel & we  & (addr == REG_COMPLETE);
    rd_claim    = sel & ~we & (addr == REG_CLAIM);
  end

  // Sources that may be claimed right now.
  always_comb begin
    eligible = pend_q & enable_q & ~inserv_q;
  end

  int_prio_enc u_elig_enc (
    .vec   (eligible),
    .valid (elig_valid),
    .idx   (best_idx)
  );

  int_prio_enc u_inserv_enc (
    .vec   (inserv_q),
    .valid (inserv_valid),
    .idx   (inserv_idx)
  );

  // Input synchronization and edge-detect history.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  // Claim/complete/W1C masks and next-state for PEND and INSERV.
  // Set terms are OR-ed in after clear terms so an edge beats a
  // same-cycle clear and a claim beats a same-cycle complete.
  always_comb begin
    rise          = sync2_q & ~sync3_q;
    claim_mask    = '0;
    if (rd_claim && elig_valid) begin
      claim_mask[best_idx] = 1'b1;
    end
    complete_mask = wr_complete ? id_to_mask(wdata[3:0]) : '0;
    pend_clr      = claim_mask | (wr_pend ? wdata[N_SRC-1:0] : '0);

    pend_d = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        pend_d[i] = rise[i] | (pend_q[i] & ~pend_clr[i]);
      end else begin
        pend_d[i] = sync2_q[i];
      end
    end

    inserv_d = (inserv_q & ~complete_mask) | claim_mask;
  end

  // ENABLE and MODE register writes.
  always_comb begin
    enable_d = wr_enable ? wdata[N_SRC-1:0] : enable_q;
    mode_d   = wr_mode   ? wdata[N_SRC-1:0] : mode_q;
  end

  // Request only when the best eligible source outranks everything in service.
  always_comb begin
    irq_d = elig_valid & (~inserv_valid | (best_idx < inserv_idx));
  end

  // Combinational read mux; upper bits always read zero.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_PEND:   rdata[N_SRC-1:0] = pend_q;
      REG_ENABLE: rdata[N_SRC-1:0] = enable_q;
      REG_MODE:   rdata[N_SRC-1:0] = mode_q;
      REG_CLAIM:  rdata = elig_valid ? (32'(best_idx) + 32'd1) : CLAIM_NONE;
      REG_INSERV: rdata[N_SRC-1:0] = inserv_q;
      default:    rdata = '0;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      sync3_q  <= '0;
      pend_q   <= '0;
      enable_q <= '0;
      mode_q   <= '0;
      inserv_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      pend_q   <= pend_d;
      enable_q <= enable_d;
      mode_q   <= mode_d;
      inserv_q <= inserv_d;
      irq_q    <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the controller.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        sel;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [7:0]  lines = '0;
  logic [31:0] rv;

  // Model state: input history (most recent first), registers, request.
  logic [7:0] m_s1, m_s2, m_s3;
  logic [7:0] m_pend, m_en, m_mode, m_ins;
  logic       m_irq;

  int_ctrl #(.N_SRC(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Index of lowest set bit, 8 when none.
  function automatic int lowest(input logic [7:0] v);
    int r;
    r = 8;
    for (int i = 7; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    int b;
    b = lowest(m_pend & m_en & ~m_ins);
    case (a)
      3'd0:    return {24'd0, m_pend};
      3'd1:    return {24'd0, m_en};
      3'd2:    return {24'd0, m_mode};
      3'd3:    return (b == 8) ? 32'd0 : 32'(b + 1);
      3'd5:    return {24'd0, m_ins};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_s3 = '0;
    m_pend = '0; m_en = '0; m_mode = '0; m_ins = '0; m_irq = 1'b0;
  endtask

  // One bus cycle: drive, check read data, advance model and DUT, check irq.
  task automatic cyc(input logic s, input logic w, input logic [2:0] a,
                     input logic [31:0] d, output logic [31:0] rd_o);
    logic [7:0] rise, clr, pend_n, ins_n, en_n, mode_n;
    logic       irq_n;
    int         b, li, cid;
    sel = s; we = w; addr = a; wdata = d; irq_in = lines;
    #1;
    rd_o = rdata;
    chk($sformatf("rdata[%0d]", a), rdata, m_read(a));
    b     = lowest(m_pend & m_en & ~m_ins);
    li    = lowest(m_ins);
    irq_n = (b < 8) && (b < li);
    rise  = m_s2 & ~m_s3;
    clr   = (s && w && a == 3'd0) ? d[7:0] : 8'h00;
    ins_n = m_ins;
    cid   = int'(d[3:0]) - 1;
    if (s && w && a == 3'd4 && cid >= 0 && cid <= 7) ins_n[cid] = 1'b0;
    if (s && !w && a == 3'd3 && b < 8) begin
      ins_n[b] = 1'b1;
      clr[b]   = 1'b1;
    end
    for (int i = 0; i < 8; i++)
      pend_n[i] = m_mode[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : m_s2[i];
    en_n   = (s && w && a == 3'd1) ? d[7:0] : m_en;
    mode_n = (s && w && a == 3'd2) ? d[7:0] : m_mode;
    @(posedge clk);
    m_s3 = m_s2; m_s2 = m_s1; m_s1 = lines;
    m_pend = pend_n; m_ins = ins_n; m_en = en_n; m_mode = mode_n; m_irq = irq_n;
    #1;
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    repeat (n) cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)), 32'd0, r);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    cyc(1'b1, 1'b1, a, d, r);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    cyc(1'b1, 1'b0, a, 32'd0, r);
  endtask

  task automatic pulse(input logic [7:0] m);
    lines = m;
    idle(1);
    lines = '0;
  endtask

  // Cycle held in reset: bus writes and input activity must have no effect.
  task automatic rst_hold();
    sel = 1'b1; we = 1'b1; addr = 3'd1; wdata = 32'hFF; irq_in = lines;
    @(posedge clk);
    #1;
    chk("rst_irq_hold", {31'd0, irq}, 32'd0);
    chk("rst_en_hold", rdata, 32'd0);
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; irq_in = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      chk($sformatf("reset_reg%0d", a), rdata, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Edge src 3: four-edge latency, claim, drop.
    wr(3'd2, 32'h08);
    wr(3'd1, 32'h08);
    pulse(8'h08);
    idle(2);
    chk("lat_edge3", {31'd0, irq}, 32'd0);
    idle(1);
    chk("lat_edge4", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    chk("claim_src3", rv, 32'd4);
    idle(1);
    chk("drop_after_claim", {31'd0, irq}, 32'd0);
    rd(3'd5, rv);
    chk("inserv_08", rv, 32'h08);
    rd(3'd0, rv);
    chk("pend3_clear", {31'd0, rv[3]}, 32'd0);
    wr(3'd4, 32'd4);

    // Two pending sources: priority, blocking, completion.
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'hFF);
    pulse(8'h24);
    idle(3);
    rd(3'd3, rv);
    chk("claim_src2", rv, 32'd3);
    idle(2);
    chk("blocked_by_2", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'd3);
    idle(1);
    chk("raise_after_cmp", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    chk("claim_src5", rv, 32'd6);
    wr(3'd4, 32'd6);
    idle(1);

    // Preemption only by strictly higher priority.
    pulse(8'h10);
    idle(3);
    rd(3'd3, rv);
    chk("claim_src4", rv, 32'd5);
    pulse(8'h02);
    idle(3);
    chk("preempt_src1", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    chk("claim_src1", rv, 32'd2);
    wr(3'd4, 32'd2);
    pulse(8'h40);
    idle(4);
    chk("no_preempt_src6", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'd5);
    idle(1);
    chk("src6_after_cmp", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    chk("claim_src6", rv, 32'd7);
    wr(3'd4, 32'd7);
    idle(2);

    // Level mode on src 0.
    wr(3'd2, 32'hFE);
    lines = 8'h01;
    idle(4);
    chk("level_raise", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    chk("level_claim", rv, 32'd1);
    idle(2);
    chk("level_blocked", {31'd0, irq}, 32'd0);
    wr(3'd4, 32'd1);
    idle(1);
    chk("level_reraise", {31'd0, irq}, 32'd1);
    rd(3'd3, rv);
    lines = 8'h00;
    idle(4);
    wr(3'd4, 32'd1);
    idle(2);
    chk("level_deasserted", {31'd0, irq}, 32'd0);

    // W1C, edge/W1C collision, ignored COMPLETE ids.
    wr(3'd2, 32'hFF);
    pulse(8'h01);
    idle(3);
    wr(3'd0, 32'h01);
    rd(3'd0, rv);
    chk("w1c_plain", rv, 32'h00);
    lines = 8'h01;
    idle(1);
    lines = 8'h00;
    idle(1);
    wr(3'd0, 32'h01);
    rd(3'd0, rv);
    chk("w1c_collision", {31'd0, rv[0]}, 32'd1);
    rd(3'd3, rv);
    wr(3'd4, 32'd0);
    wr(3'd4, 32'd9);
    rd(3'd5, rv);
    chk("cmp_ignored", rv, 32'h01);
    wr(3'd4, 32'd1);
    idle(1);

    // Asynchronous reset while a source is in service.
    pulse(8'h10);
    idle(3);
    rd(3'd3, rv);
    pulse(8'h02);
    idle(3);
    rd(3'd5, rv);
    chk("pre_rst_inserv", rv, 32'h10);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    m_reset();
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      addr = 3'(a);
      #1;
      chk($sformatf("async_rst_reg%0d", a), rdata, 32'd0);
    end
    lines = 8'h01;
    repeat (3) rst_hold();
    reset = 1'b1;
    wr(3'd2, 32'hFF);
    wr(3'd1, 32'hFF);
    idle(4);
    rd(3'd3, rv);
    chk("held_line_pends", rv, 32'd1);
    wr(3'd4, 32'd1);
    idle(4);
    chk("held_line_once", {31'd0, irq}, 32'd0);
    lines = 8'h00;

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) lines = lines ^ 8'(1 << $urandom_range(0, 7));
      case ($urandom_range(0, 9))
        4:       rd(3'd3, rv);
        5:       wr(3'd4, 32'($urandom_range(0, 10)));
        6:       wr(3'd0, $urandom);
        7:       wr(3'd1, $urandom);
        8:       wr(3'd2, $urandom);
        9:       rd(3'($urandom_range(0, 7)), rv);
        default: idle(1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 8: number of interrupt sources; only 8 is supported.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port irq_in, input, 8: raw device interrupt lines, asynchronous to clk; bit i is source id i.
REQ-005 SHALL have port sel, input, 1: register access strobe, one cycle per access.
REQ-006 SHALL have port we, input, 1: 1 = write, 0 = read; valid when sel=1.
REQ-007 SHALL have port addr, input, 3: word register index (bus byte address bits 4:2).
REQ-008 SHALL have port wdata, input, 32: write data.
REQ-009 SHALL have port rdata, output, 32: combinational read data for current addr.
REQ-010 SHALL have port irq, output, 1: registered interrupt request, wired to one CP0 HWInt bit.

Function
REQ-011 SHALL pass each irq_in bit through a 2-flop synchronizer, then a third flop for edge detection.
REQ-012 SHALL implement registers PEND (idx 0, RO/W1C), ENABLE (idx 1, RW, bits 7:0), MODE (idx 2, RW, bit=1 edge, 0 level), CLAIM (idx 3, read with side effect), COMPLETE (idx 4, WO), INSERV (idx 5, RO); idx 6-7 read 0, writes ignored; rdata bits 31:8 read 0.
REQ-013 SHALL, in edge mode, set PEND[i] on synchronized rising edge and hold it until claimed or W1C-cleared.
REQ-014 SHALL, in level mode, load PEND[i] each cycle from the synchronized level; W1C has no lasting effect.
REQ-015 SHALL give set priority over clear when an edge and a W1C or claim hit the same bit in the same cycle.
REQ-016 SHALL define eligible = PEND & ENABLE & ~INSERV and best = lowest-index eligible bit (id 0 highest priority).
REQ-017 SHALL register irq <= eligible nonzero AND (INSERV empty OR best index < lowest INSERV index), i.e. only strictly higher priority preempts.
REQ-018 SHALL return CLAIM read data = best+1 (1..8), or 0 when none eligible, computed from current-cycle state.
REQ-019 SHALL, on a CLAIM read (sel=1, we=0, addr=3) with nonzero result, set INSERV[best] and clear PEND[best] if edge mode, at the same clock edge.
REQ-020 SHALL, on a COMPLETE write, clear INSERV[wdata[3:0]-1] when wdata[3:0] is 1..8; other values are ignored.
REQ-021 SHALL apply a COMPLETE and a CLAIM of the same id in the same cycle as claim wins (not possible on a single bus, but defined).
REQ-022 SHALL produce latency from irq_in rise to irq rise of exactly 4 clk edges when the source is enabled and not blocked.
REQ-023 SHALL drop irq on the edge after a claim removes the only eligible source.
REQ-024 SHALL leave level-mode sources claimed-but-asserted blocked by INSERV until completed; after COMPLETE they re-raise irq in 1 cycle if still asserted.

Reset
REQ-025 SHALL, while reset=0, asynchronously clear synchronizers, PEND, ENABLE, MODE, INSERV and irq to 0.
REQ-026 SHALL ignore bus accesses and irq_in edges while reset=0; the first edge detect after release compares against 0, so a line held high in edge mode pends once.

Structure
REQ-027 SHALL place N_SRC, register indices and the CLAIM-none code (0) in shared package int_ctrl_pkg.
REQ-028 SHALL use one sub-module int_prio_enc: 8-bit vector in, valid plus 3-bit lowest-set index out; instantiated twice (eligible, INSERV).

Verification
REQ-029 SHALL cover: edge mode src 3 enabled, irq_in[3] pulses 1 cycle -> irq=1 at 4th edge; CLAIM reads 4; PEND[3]=0, INSERV=0x08; irq=0 next edge.
REQ-030 SHALL cover: sources 5 and 2 both pend, ENABLE=0xFF -> CLAIM reads 3, then with 2 in service irq=0; COMPLETE 3 -> irq=1; CLAIM reads 6.
REQ-031 SHALL cover preemption: src 4 in service, src 1 pends -> irq=1; src 6 pends instead -> irq stays 0.
REQ-032 SHALL cover level mode: irq_in[0] held high, claim, COMPLETE 1 -> irq re-raised 1 cycle later; deassert input before COMPLETE -> irq stays 0.
REQ-033 SHALL cover W1C and collision: W1C PEND=0x01 in the same cycle as a new edge on src 0 -> PEND[0] remains 1; COMPLETE 0 and 9 -> INSERV unchanged.
REQ-034 SHALL cover reset mid-service: INSERV=0x10, irq=1, reset pulsed low asynchronously -> all registers 0, irq=0 immediately.
